// File: rtl/contador_seq_monitor.sv
// Sequence monitor for a free-running counter: checks each sample is previous+1,
// reports lock status, step errors and wrap-arounds with saturating counters.
module contador_seq_monitor #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned ERRCNT_W = 8,
  parameter int unsigned WRAP_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CNT_W-1:0]    contador,
  input  logic                clear_err,
  output logic                locked,
  output logic                err_pulse,
  output logic                err_sticky,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                wrap_pulse,
  output logic [WRAP_W-1:0]   wrap_count
);

  localparam int unsigned GoodW = $clog2(LOCK_LEN + 1);

  localparam logic [CNT_W-1:0]    CntMax   = '1;
  localparam logic [ERRCNT_W-1:0] ErrMax   = '1;
  localparam logic [WRAP_W-1:0]   WrapMax  = '1;
  localparam logic [GoodW-1:0]    LockLenW = GoodW'(LOCK_LEN);

  typedef enum logic [1:0] {StAcq, StTrack, StLocked} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] prev_q;
  logic [GoodW-1:0] good_cnt_q;

  logic [CNT_W-1:0] prev_inc;
  logic             step_ok;
  logic             err_evt;
  logic             wrap_evt;

  always_comb begin
    prev_inc = prev_q + CNT_W'(1);
    step_ok  = (contador == prev_inc);
    err_evt  = (state_q == StLocked) && !step_ok;
    // A good step out of the all-ones value can only land on zero.
    wrap_evt = (state_q != StAcq) && step_ok && (prev_q == CntMax);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StAcq;
      prev_q     <= '0;
      good_cnt_q <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      prev_q     <= contador;
      err_pulse  <= err_evt;
      wrap_pulse <= wrap_evt;

      if (wrap_evt && (wrap_count != WrapMax)) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end

      // A same-edge error overrides clear_err and restarts the count at one.
      if (err_evt) begin
        err_sticky <= 1'b1;
        if (clear_err) begin
          err_count <= ERRCNT_W'(1);
        end else if (err_count != ErrMax) begin
          err_count <= err_count + ERRCNT_W'(1);
        end
      end else if (clear_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end

      unique case (state_q)
        StAcq: begin
          state_q    <= StTrack;
          good_cnt_q <= '0;
        end
        StTrack: begin
          if (step_ok) begin
            if (good_cnt_q == LockLenW - GoodW'(1)) begin
              state_q    <= StLocked;
              locked     <= 1'b1;
              good_cnt_q <= LockLenW;
            end else begin
              good_cnt_q <= good_cnt_q + GoodW'(1);
            end
          end else begin
            good_cnt_q <= '0;
          end
        end
        StLocked: begin
          if (!step_ok) begin
            state_q    <= StTrack;
            locked     <= 1'b0;
            good_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= StAcq;
          locked     <= 1'b0;
          good_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_seq_monitor.sv
// Bench for contador_seq_monitor: fixed vector table, hand-written corner cases and
// randomized steps checked against a run-length reference model.
module tb_contador_seq_monitor;

  localparam int CNT_W    = 4;
  localparam int LOCK_LEN = 4;
  localparam int ERRCNT_W = 8;
  localparam int WRAP_W   = 8;
  localparam int CNT_MOD  = 1 << CNT_W;
  localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [CNT_W-1:0]    contador;
  logic                clear_err;
  logic                locked;
  logic                err_pulse;
  logic                err_sticky;
  logic [ERRCNT_W-1:0] err_count;
  logic                wrap_pulse;
  logic [WRAP_W-1:0]   wrap_count;

  always #5 clk = ~clk;

  contador_seq_monitor #(
    .CNT_W   (CNT_W),
    .LOCK_LEN(LOCK_LEN),
    .ERRCNT_W(ERRCNT_W),
    .WRAP_W  (WRAP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .contador  (contador),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count)
  );

  typedef struct {
    int v;
    bit clr;
    bit locked;
    bit ep;
    bit es;
    int ec;
    bit wp;
    int wc;
  } vec_t;

  vec_t vecs[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: locked means the current run of good steps is at least LOCK_LEN.
  bit m_valid;
  int m_prev;
  int m_run;
  bit m_err;
  bit m_wrap;
  bit m_sticky;
  int m_errc;
  int m_wrapc;

  int cur;
  int nv;
  int r;
  bit clr;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_prev   = 0;
    m_run    = 0;
    m_err    = 1'b0;
    m_wrap   = 1'b0;
    m_sticky = 1'b0;
    m_errc   = 0;
    m_wrapc  = 0;
  endtask

  task automatic model_step(input int v, input bit c);
    bit good;
    if (!m_valid) begin
      m_valid = 1'b1;
      m_run   = 0;
      m_err   = 1'b0;
      m_wrap  = 1'b0;
    end else begin
      good   = (v == (m_prev + 1) % CNT_MOD);
      m_err  = !good && (m_run >= LOCK_LEN);
      m_wrap = good && (v == 0);
      m_run  = good ? m_run + 1 : 0;
    end
    m_prev = v;
    if (m_err) begin
      m_sticky = 1'b1;
      m_errc   = c ? 1 : ((m_errc < ERR_MAX) ? m_errc + 1 : ERR_MAX);
    end else if (c) begin
      m_sticky = 1'b0;
      m_errc   = 0;
    end
    if (m_wrap) m_wrapc = (m_wrapc < WRAP_MAX) ? m_wrapc + 1 : WRAP_MAX;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"}, int'(locked), int'(m_run >= LOCK_LEN));
    check({tag, ".err_pulse"}, int'(err_pulse), int'(m_err));
    check({tag, ".err_sticky"}, int'(err_sticky), int'(m_sticky));
    check({tag, ".err_count"}, int'(err_count), m_errc);
    check({tag, ".wrap_pulse"}, int'(wrap_pulse), int'(m_wrap));
    check({tag, ".wrap_count"}, int'(wrap_count), m_wrapc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".locked"}, int'(locked), 0);
    check({tag, ".err_pulse"}, int'(err_pulse), 0);
    check({tag, ".err_sticky"}, int'(err_sticky), 0);
    check({tag, ".err_count"}, int'(err_count), 0);
    check({tag, ".wrap_pulse"}, int'(wrap_pulse), 0);
    check({tag, ".wrap_count"}, int'(wrap_count), 0);
  endtask

  // Apply one sample, clock it in, then advance the model.
  task automatic drive(input int v, input bit c);
    contador  = CNT_W'(v);
    clear_err = c;
    @(posedge clk);
    #1;
    model_step(v, c);
  endtask

  task automatic add(input int v, input bit c, input bit l, input bit ep, input bit es,
                     input int ec, input bit wp, input int wc);
    vec_t e;
    e.v = v; e.clr = c; e.locked = l; e.ep = ep; e.es = es; e.ec = ec; e.wp = wp; e.wc = wc;
    vecs.push_back(e);
  endtask

  initial begin
    //   v  clr lk ep es ec wp wc
    add( 0, 0, 0, 0, 0, 0, 0, 0);
    add( 1, 0, 0, 0, 0, 0, 0, 0);
    add( 2, 0, 0, 0, 0, 0, 0, 0);
    add( 3, 0, 0, 0, 0, 0, 0, 0);
    add( 4, 0, 1, 0, 0, 0, 0, 0);
    add( 5, 0, 1, 0, 0, 0, 0, 0);
    add( 7, 0, 0, 1, 1, 1, 0, 0);
    add( 8, 0, 0, 0, 1, 1, 0, 0);
    add( 9, 0, 0, 0, 1, 1, 0, 0);
    add(10, 0, 0, 0, 1, 1, 0, 0);
    add(11, 0, 1, 0, 1, 1, 0, 0);
    add(12, 0, 1, 0, 1, 1, 0, 0);
    add(13, 0, 1, 0, 1, 1, 0, 0);
    add(14, 0, 1, 0, 1, 1, 0, 0);
    add(15, 0, 1, 0, 1, 1, 0, 0);
    add( 0, 0, 1, 0, 1, 1, 1, 1);
    add( 1, 0, 1, 0, 1, 1, 0, 1);
    add( 1, 0, 0, 1, 1, 2, 0, 1);
    add( 1, 0, 0, 0, 1, 2, 0, 1);
    add( 2, 1, 0, 0, 0, 0, 0, 1);
    add( 3, 0, 0, 0, 0, 0, 0, 1);
    add( 4, 0, 0, 0, 0, 0, 0, 1);
    add( 5, 0, 1, 0, 0, 0, 0, 1);
    add( 9, 1, 0, 1, 1, 1, 0, 1);
    add(15, 0, 0, 0, 1, 1, 0, 1);
    add( 0, 0, 0, 0, 1, 1, 1, 2);

    reset     = 1'b1;
    contador  = '0;
    clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].clr);
      check($sformatf("vec%0d.locked", i), int'(locked), int'(vecs[i].locked));
      check($sformatf("vec%0d.err_pulse", i), int'(err_pulse), int'(vecs[i].ep));
      check($sformatf("vec%0d.err_sticky", i), int'(err_sticky), int'(vecs[i].es));
      check($sformatf("vec%0d.err_count", i), int'(err_count), vecs[i].ec);
      check($sformatf("vec%0d.wrap_pulse", i), int'(wrap_pulse), int'(vecs[i].wp));
      check($sformatf("vec%0d.wrap_count", i), int'(wrap_count), vecs[i].wc);
    end
    cur = vecs[vecs.size()-1].v;

    // Randomized steps: mostly good increments, some holds, jumps and clears.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 15);
      if (r < 13) nv = (cur + 1) % CNT_MOD;
      else if (r == 13) nv = cur;
      else nv = $urandom_range(0, CNT_MOD - 1);
      clr = ($urandom_range(0, 15) == 0);
      drive(nv, clr);
      check_model($sformatf("rand%0d", i));
      cur = nv;
    end

    // Repeated relock then skip drives err_count into saturation.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < LOCK_LEN; k++) begin
        cur = (cur + 1) % CNT_MOD;
        drive(cur, 1'b0);
        check_model("sat_good");
      end
      cur = (cur + 2) % CNT_MOD;
      drive(cur, 1'b0);
      check_model("sat_skip");
    end
    check("sat.err_count", int'(err_count), ERR_MAX);
    check("sat.err_sticky", int'(err_sticky), 1);

    cur = (cur + 1) % CNT_MOD;
    drive(cur, 1'b1);
    check("clear.err_count", int'(err_count), 0);
    check("clear.err_sticky", int'(err_sticky), 0);
    check_model("clear");

    for (int k = 0; k < LOCK_LEN + 2; k++) begin
      cur = (cur + 1) % CNT_MOD;
      drive(cur, 1'b0);
      check_model("relock");
    end
    check("prereset.locked", int'(locked), 1);

    // Asynchronous reset between edges must clear outputs before the next edge.
    #2 reset = 1'b1;
    #1;
    check_zero("async_reset");
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k <= LOCK_LEN + 1; k++) begin
      drive(k, 1'b0);
      check_model($sformatf("post_reset%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
